register_dump_reader: RTL and testbench

//  Debug-side reader of the 32x32 register bank. On start_i it walks addresses 0..N_REGISTER-1 on the

---
 rtl/register_dump_reader_pkg.sv | 25 ++
 rtl/register_dump_reader_if.sv | 27 ++
 rtl/register_dump_reader_word_byte_serializer.sv | 60 ++++++
 rtl/register_dump_reader.sv | 126 ++++++++++++
 tb/tb_register_dump_reader.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/register_dump_reader_pkg.sv
// rtl/register_dump_reader_pkg.sv - shared constants, FSM encoding and helpers for the register dump reader
package register_dump_reader_pkg;

    localparam int DEF_NB_REG     = 5;
    localparam int DEF_NB_DATA    = 32;
    localparam int DEF_N_REGISTER = 32;
    localparam int DEF_NB_BYTE    = 8;

    localparam int BYTES_PER_WORD       = DEF_NB_DATA / DEF_NB_BYTE;
    localparam bit BYTE_ORDER_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

endpackage

// File: rtl/register_dump_reader_if.sv
// rtl/register_dump_reader_if.sv - bank read port, byte stream and control handshake of the dump reader
interface register_dump_reader_if
    import register_dump_reader_pkg::*;
#(
    parameter int NB_REG  = DEF_NB_REG,
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_BYTE = DEF_NB_BYTE
);
    logic               start_i;
    logic [NB_REG-1:0]  rd_addr_o;
    logic [NB_DATA-1:0] rd_data_i;
    logic [NB_BYTE-1:0] tx_data_o;
    logic               tx_valid_o;
    logic               tx_ready_i;
    logic               busy_o;
    logic               done_o;

    modport master (
        input  start_i, rd_data_i, tx_ready_i,
        output rd_addr_o, tx_data_o, tx_valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, rd_data_i, tx_ready_i,
        input  rd_addr_o, tx_data_o, tx_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/register_dump_reader_word_byte_serializer.sv
// rtl/register_dump_reader_word_byte_serializer.sv - loads one word and emits it as valid/ready bytes
module word_byte_serializer
    import register_dump_reader_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_BYTE = DEF_NB_BYTE
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_i,
    input  logic               ready_i,
    output logic [NB_BYTE-1:0] data_o,
    output logic               valid_o,
    output logic               last_o
);
    localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               accept;

    assign accept  = valid_q && ready_i;
    assign last_o  = accept && (count_q == CNT_W'(BPW - 1));
    assign valid_o = valid_q;
    assign data_o  = BYTE_ORDER_LSB_FIRST ? shift_q[NB_BYTE-1:0] : shift_q[NB_DATA-1 -: NB_BYTE];

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            count_d = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            // Shifting in zeros leaves data_o at 0 once the word is drained.
            shift_d = BYTE_ORDER_LSB_FIRST ? (shift_q >> NB_BYTE) : (shift_q << NB_BYTE);
            count_d = count_q + 1'b1;
            if (last_o) begin
                valid_d = 1'b0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/register_dump_reader.sv
// rtl/register_dump_reader.sv - register bank dump FSM; REG_DUMP_CHECKSUM_EN appends an XOR checksum byte
module register_dump_reader
    import register_dump_reader_pkg::*;
#(
    parameter int NB_REG     = DEF_NB_REG,
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int N_REGISTER = DEF_N_REGISTER,
    parameter int NB_BYTE    = DEF_NB_BYTE
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    register_dump_reader_if.master bus
);
`ifdef REG_DUMP_CHECKSUM_EN
    localparam state_t ST_AFTER_LAST = ST_CKSUM;
`else
    localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

    state_t             state_q, state_d;
    logic [NB_REG-1:0]  index_q, index_d;
    logic               ser_load;
    logic               ser_valid;
    logic               ser_last;
    logic [NB_BYTE-1:0] ser_data;
    logic               last_reg;

    assign last_reg = (index_q == NB_REG'(N_REGISTER - 1));

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .load_i  (ser_load),
        .word_i  (bus.rd_data_i),
        .ready_i (bus.tx_ready_i),
        .data_o  (ser_data),
        .valid_o (ser_valid),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_READ;
                    index_d = '0;
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                // Bank output is valid during this cycle; capture on its closing edge.
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_last) begin
                    if (last_reg) begin
                        state_d = ST_AFTER_LAST;
                    end else begin
                        state_d = ST_READ;
                        index_d = index_q + 1'b1;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CKSUM: begin
                if (bus.tx_ready_i) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                index_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == ST_IDLE && bus.start_i) begin
            cksum_d = '0;
        end else if (state_q == ST_SEND && ser_valid && bus.tx_ready_i) begin
            cksum_d = cksum_q ^ ser_data;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign bus.tx_valid_o = ser_valid || (state_q == ST_CKSUM);
    assign bus.tx_data_o  = (state_q == ST_CKSUM) ? cksum_q : ser_data;
`else
    assign bus.tx_valid_o = ser_valid;
    assign bus.tx_data_o  = ser_data;
`endif

    assign bus.rd_addr_o = index_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.done_o    = (state_q == ST_DONE);
endmodule

// File: tb/tb_register_dump_reader.sv
// tb/tb_register_dump_reader.sv - randomized self-checking bench for register_dump_reader
module tb_register_dump_reader;
    import register_dump_reader_pkg::*;

    localparam int NREG = DEF_N_REGISTER;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_dump_reader_if bus ();

    register_dump_reader dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    logic [31:0] regs [NREG];

    always @(posedge clk) bus.rd_data_i <= regs[bus.rd_addr_o];

    int checks = 0;
    int errors = 0;

    logic [7:0] obs[$];
    logic [7:0] exp_q[$];
    int         addr_q[$];
    int         done_cnt;
    int         stall_err;
    bit         prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int pct);
        return ($urandom_range(0, 99) >= pct);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (!bus.tx_valid_o || bus.tx_data_o !== prev_data)) stall_err++;
            prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
            prev_data  = bus.tx_data_o;
            if (bus.tx_valid_o && bus.tx_ready_i) obs.push_back(bus.tx_data_o);
            if (bus.done_o) done_cnt++;
            if (bus.busy_o && (addr_q.size() == 0 || addr_q[$] != int'(bus.rd_addr_o)))
                addr_q.push_back(int'(bus.rd_addr_o));
        end
    end

    task automatic build_expected();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < NREG; r++) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                exp_q.push_back(regs[r][8*b +: 8]);
                x = x ^ regs[r][8*b +: 8];
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_dump(input int stall_pct, input bit poke, input int abort_at);
        int cyc;
        bit fin;
        bit seen;
        int bad;
        build_expected();
        obs.delete();
        addr_q.delete();
        done_cnt   = 0;
        stall_err  = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1 bus.start_i = 1'b1;
        bus.tx_ready_i = rdy(stall_pct);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        bus.tx_ready_i = rdy(stall_pct);
        cyc  = 0;
        fin  = 1'b0;
        seen = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            #1;
            if (!seen && bus.tx_valid_o) begin
                seen = 1'b1;
                check("first_valid_latency", cyc, 2);
            end
            if (abort_at >= 0 && obs.size() == abort_at && bus.tx_valid_o) begin
                check("abort_byte", bus.tx_data_o, exp_q[abort_at-1]);
                rst = 1'b1;
                #1;
                check("abort_tx_valid", bus.tx_valid_o, 0);
                check("abort_tx_data", bus.tx_data_o, 0);
                check("abort_busy", bus.busy_o, 0);
                check("abort_done", bus.done_o, 0);
                check("abort_rd_addr", bus.rd_addr_o, 0);
                @(posedge clk);
                #1 rst = 1'b0;
                bus.start_i = 1'b0;
                prev_stall  = 1'b0;
                check("abort_no_done", done_cnt, 0);
                return;
            end
            if (bus.done_o) begin
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                bus.tx_ready_i = rdy(stall_pct);
                bus.start_i    = poke && ($urandom_range(0, 7) == 0);
                cyc++;
            end
        end
        check("done_seen", fin, 1);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        check("busy_after_done", bus.busy_o, 0);
        check("nbytes", obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), obs[i], exp_q[i]);
        check("done_cnt", done_cnt, 1);
        check("stall_err", stall_err, 0);
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
        check("addr_len", addr_q.size(), NREG);
        check("addr_bad", bad, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = 32'hA500_0000 | i;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rd_addr", bus.rd_addr_o, 0);
        check("rst_tx_data", bus.tx_data_o, 0);
        check("rst_tx_valid", bus.tx_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);

        run_dump(0, 1'b0, -1);
`ifdef REG_DUMP_CHECKSUM_EN
        if (obs.size() > 0) check("cksum_default", obs[obs.size()-1], 8'h00);
`endif
        run_dump(40, 1'b0, -1);

        run_dump(0, 1'b0, 7 * BYTES_PER_WORD + 2 + 1);
        run_dump(30, 1'b0, -1);

        run_dump(20, 1'b1, -1);
        repeat (10) @(negedge clk);
        check("quiet_busy", bus.busy_o, 0);
        check("quiet_done_cnt", done_cnt, 1);

        regs[3] = 32'h0000_00FF;
        run_dump(25, 1'b0, -1);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREG; i++) regs[i] = $urandom;
            run_dump($urandom_range(0, 60), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
